// File: rtl/pingpong_pkg.sv
// pingpong_pkg: shared bank-state encoding for the ping-pong buffer and its banks
package pingpong_pkg;
    typedef enum logic [1:0] {
        BANK_EMPTY   = 2'd0,
        BANK_FILLING = 2'd1,
        BANK_FULL    = 2'd2
    } bank_state_e;
endpackage

// File: rtl/pingpong_bank.sv
// pingpong_bank: one DEPTH x WIDTH bank with fill count, frame length and EMPTY/FILLING/FULL state
//   clk, reset_n       clock, asynchronous active-low reset
//   flush_i            synchronous clear of state, count and length
//   wr_en_i            accepted beat targeted at this bank
//   wr_data_i          beat data
//   wr_last_i          beat closes the bank early
//   rd_idx_i           read index into storage
//   rel_i              last beat of the bank read, bank returns to EMPTY
//   state_o            current bank state
//   close_o            this cycle's write closes the bank
//   len_o              beats held once closed
//   rd_data_o          storage word at rd_idx_i
module pingpong_bank
    import pingpong_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             flush_i,
    input  logic             wr_en_i,
    input  logic [WIDTH-1:0] wr_data_i,
    input  logic             wr_last_i,
    input  logic [AW-1:0]    rd_idx_i,
    input  logic             rel_i,
    output bank_state_e      state_o,
    output logic             close_o,
    output logic [AW:0]      len_o,
    output logic [WIDTH-1:0] rd_data_o
);
    localparam logic [AW-1:0] CNT_MAX = AW'(DEPTH - 1);
    bank_state_e      state_q, state_d;
    logic [AW-1:0]    cnt_q, cnt_d;
    logic [AW:0]      len_q, len_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    // Filling to capacity and an explicit last beat are the same single close event.
    assign close_o   = wr_en_i && (cnt_q == CNT_MAX || wr_last_i);
    assign state_o   = state_q;
    assign len_o     = len_q;
    assign rd_data_o = mem_q[rd_idx_i];
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        len_d   = len_q;
        if (flush_i) begin
            state_d = BANK_EMPTY;
            cnt_d   = '0;
            len_d   = '0;
        end else if (close_o) begin
            state_d = BANK_FULL;
            cnt_d   = '0;
            len_d   = {1'b0, cnt_q} + (AW+1)'(1);
        end else if (wr_en_i) begin
            state_d = BANK_FILLING;
            cnt_d   = cnt_q + AW'(1);
        end else if (rel_i) begin
            state_d = BANK_EMPTY;
        end
    end
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= BANK_EMPTY;
            cnt_q   <= '0;
            len_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
        end
    end
    // Storage needs no reset: contents are only visible while the bank is FULL.
    always_ff @(posedge clk) begin
        if (wr_en_i && !flush_i) mem_q[cnt_q] <= wr_data_i;
    end
endmodule

// File: rtl/pingpong_buffer_param.sv
// pingpong_buffer_param: two-bank ping-pong buffer, producer fills one bank while consumer drains the other
//   clk, reset_n                    clock, asynchronous active-low reset
//   flush                           synchronous clear, wins over any handshake that cycle
//   in_valid/in_ready/in_data/in_last   producer stream; in_last closes the bank early
//   out_valid/out_ready/out_data/out_last consumer stream; out_data is 0 when not valid
//   banks_full                      bit b set while bank b is closed and awaiting/under drain
module pingpong_buffer_param
    import pingpong_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_last,
    output logic [1:0]       banks_full
);
    localparam int AW = $clog2(DEPTH);
    logic             wbank_q, wbank_d, rbank_q, rbank_d;
    logic [AW-1:0]    rd_idx_q, rd_idx_d;
    bank_state_e      state [2];
    logic [WIDTH-1:0] rd_data [2];
    logic [AW:0]      len [2];
    logic [1:0]       close, wr_en, rel;
    logic             wr_acc, rd_acc;
    // Readiness comes from registered bank state only, so a bank drained this cycle refills next cycle.
    assign in_ready  = reset_n && state[wbank_q] != BANK_FULL;
    assign out_valid = state[rbank_q] == BANK_FULL;
    assign out_last  = out_valid && {1'b0, rd_idx_q} == len[rbank_q] - (AW+1)'(1);
    assign out_data  = out_valid ? rd_data[rbank_q] : '0;
    assign wr_acc    = in_valid && in_ready && !flush;
    assign rd_acc    = out_valid && out_ready && !flush;
    for (genvar g = 0; g < 2; g++) begin : g_bank
        assign banks_full[g] = state[g] == BANK_FULL;
        assign wr_en[g]      = wr_acc && wbank_q == 1'(g);
        assign rel[g]        = rd_acc && out_last && rbank_q == 1'(g);
        pingpong_bank #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW)) u_bank (
            .clk       (clk),
            .reset_n   (reset_n),
            .flush_i   (flush),
            .wr_en_i   (wr_en[g]),
            .wr_data_i (in_data),
            .wr_last_i (in_last),
            .rd_idx_i  (rd_idx_q),
            .rel_i     (rel[g]),
            .state_o   (state[g]),
            .close_o   (close[g]),
            .len_o     (len[g]),
            .rd_data_o (rd_data[g])
        );
    end
    always_comb begin
        wbank_d  = flush ? 1'b0 : wbank_q ^ |close;
        rbank_d  = flush ? 1'b0 : rbank_q ^ |rel;
        rd_idx_d = flush ? '0 : !rd_acc ? rd_idx_q : out_last ? '0 : rd_idx_q + AW'(1);
    end
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wbank_q  <= 1'b0;
            rbank_q  <= 1'b0;
            rd_idx_q <= '0;
        end else begin
            wbank_q  <= wbank_d;
            rbank_q  <= rbank_d;
            rd_idx_q <= rd_idx_d;
        end
    end
endmodule

// File: tb/tb_pingpong_buffer_param.sv
// tb_pingpong_buffer_param: randomized and directed stimulus against a frame-queue reference model
module tb_pingpong_buffer_param;
    localparam int WIDTH = 8;
    localparam int DEPTH = 4;
    logic             clk = 1'b0, reset_n = 1'b0, flush = 1'b0;
    logic             in_valid = 1'b0, in_last = 1'b0, out_ready = 1'b0;
    logic [WIDTH-1:0] in_data = '0;
    logic             in_ready, out_valid, out_last;
    logic [WIDTH-1:0] out_data;
    logic [1:0]       banks_full;
    int n_tests = 0, n_fail = 0;
    int outq[$], lens[$], part[$];
    int pos = 0, rb = 0;
    logic [8:0] src[$];

    pingpong_buffer_param #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset_n(reset_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
        .banks_full(banks_full)
    );

    always #5 clk = ~clk;

    task automatic check(string tag, int got, int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_clear();
        outq.delete();
        lens.delete();
        part.delete();
        pos = 0;
        rb  = 0;
    endtask

    // Closed frames form a FIFO of at most two; the head frame lives in bank rb.
    task automatic cycle();
        bit ev, er;
        int ebf;
        @(negedge clk);
        ev  = lens.size() > 0;
        er  = lens.size() < 2;
        ebf = lens.size() == 0 ? 0 : lens.size() == 1 ? (1 << rb) : 3;
        check("in_ready", in_ready, er);
        check("out_valid", out_valid, ev);
        check("out_data", out_data, ev ? outq[0] : 0);
        check("banks_full", banks_full, ebf);
        if (ev) check("out_last", out_last, pos == lens[0] - 1);
        @(posedge clk);
        if (flush) begin
            model_clear();
        end else begin
            if (ev && out_ready) begin
                void'(outq.pop_front());
                pos++;
                if (pos == lens[0]) begin
                    void'(lens.pop_front());
                    pos = 0;
                    rb ^= 1;
                end
            end
            if (in_valid && er) begin
                part.push_back(int'(in_data));
                if (src.size() > 0) void'(src.pop_front());
                if (in_last || part.size() == DEPTH) begin
                    foreach (part[i]) outq.push_back(part[i]);
                    lens.push_back(part.size());
                    part.delete();
                end
            end
        end
    endtask

    task automatic push(int first, int last_v, bit close_last);
        for (int v = first; v <= last_v; v++)
            src.push_back({close_last && v == last_v, 8'(v)});
    endtask

    task automatic run(int n, int vpct, int rpct, int fpct);
        repeat (n) begin
            in_valid  = src.size() > 0 && $urandom_range(99) < vpct;
            in_data   = src.size() > 0 ? src[0][7:0] : 8'($urandom);
            in_last   = src.size() > 0 ? src[0][8] : 1'b0;
            out_ready = $urandom_range(99) < rpct;
            flush     = $urandom_range(99) < fpct;
            cycle();
            #1;
        end
        in_valid = 1'b0;
        flush    = 1'b0;
    endtask

    initial begin
        repeat (2) @(negedge clk);
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_out_last", out_last, 0);
        check("rst_banks_full", banks_full, 0);
        @(posedge clk);
        #1 reset_n = 1'b1;
        model_clear();
        #1 check("rel_in_ready", in_ready, 1);
        // continuous stream
        push(1, 8, 0);
        run(14, 100, 100, 0);
        // backpressure until both banks are closed
        push(1, 9, 0);
        run(10, 100, 0, 0);
        check("bp_in_ready", in_ready, 0);
        check("bp_banks_full", banks_full, 3);
        run(16, 100, 100, 0);
        // short frame, then a beat that opens the other bank
        push(7, 8, 1);
        push(9, 9, 0);
        run(8, 100, 100, 0);
        push(10, 12, 0);
        run(10, 100, 100, 0);
        // gap in the producer stream
        push(1, 6, 0);
        run(6, 100, 100, 0);
        run(3, 0, 100, 0);
        push(7, 10, 0);
        run(12, 100, 100, 0);
        // asynchronous reset with a closed frame pending
        push(1, 6, 0);
        run(8, 100, 0, 0);
        check("pre_rst_out_valid", out_valid, 1);
        reset_n = 1'b0;
        #1;
        model_clear();
        src.delete();
        check("mid_rst_out_valid", out_valid, 0);
        check("mid_rst_in_ready", in_ready, 0);
        check("mid_rst_out_data", out_data, 0);
        @(posedge clk);
        #1 reset_n = 1'b1;
        push(1, 4, 0);
        run(10, 100, 100, 0);
        // flush against an offered beat
        push(1, 3, 0);
        run(3, 100, 0, 0);
        in_valid = 1'b1;
        in_data  = 8'd77;
        flush    = 1'b1;
        cycle();
        #1;
        flush    = 1'b0;
        in_valid = 1'b0;
        src.delete();
        check("flush_in_ready", in_ready, 1);
        check("flush_banks_full", banks_full, 0);
        check("flush_out_valid", out_valid, 0);
        // random traffic
        repeat (60) begin
            repeat ($urandom_range(1, 12)) src.push_back({$urandom_range(99) < 25, 8'($urandom)});
            run(30, $urandom_range(20, 100), $urandom_range(0, 100), 1);
        end
        run(40, 100, 100, 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
